ad9253_frame_gen: RTL

AD9253_FRAME_GEN -- requirements
Module: ad9253_frame_gen

---
 rtl/ad9253_pkg.sv | 40 ++++
 rtl/ad9253_lane_slip.sv | 26 ++
 rtl/ad9253_frame_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ad9253_pkg.sv
// Shared constants and helpers for the AD9253 frame/test-pattern generator.
package ad9253_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_RUN
  } state_t;

  localparam logic [2:0] MODE_NORMAL  = 3'd0;
  localparam logic [2:0] MODE_CHECKER = 3'd1;
  localparam logic [2:0] MODE_PN9     = 3'd2;
  localparam logic [2:0] MODE_USER    = 3'd3;
  localparam logic [2:0] MODE_RAMP    = 3'd4;

  localparam logic [7:0]  FCO_PAT = 8'hF0;
  localparam logic [15:0] CHK_A   = 16'hAAA8;
  localparam logic [15:0] CHK_B   = 16'h5554;

  // x^9 + x^5 + 1, shifting left, oldest bit out first
  localparam int PN9_TAP_HI = 8;
  localparam int PN9_TAP_LO = 4;
  localparam int PN_BITS    = 14;

  // Returns {next_state[8:0], word_bits[13:0]}
  function automatic logic [22:0] pn9_word(
    input logic [8:0] s
  );
    logic [8:0]  r;
    logic [13:0] w;
    r = s;
    w = '0;
    for (int i = 0; i < PN_BITS; i++) begin
      w = {w[12:0], r[PN9_TAP_HI]};
      r = {r[7:0], r[PN9_TAP_HI] ^ r[PN9_TAP_LO]};
    end
    return {r, w};
  endfunction

endpackage

// File: rtl/ad9253_lane_slip.sv
// One output lane: registers the raw word and picks an 8-bit window
// out of {previous, current} at the current bit offset.
module ad9253_lane_slip (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw,
  input  logic [2:0] ofs,
  output logic [7:0] word
);

  logic [7:0]  prev;
  logic [15:0] cat;

  assign cat = {prev, raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= '0;
      word <= '0;
    end else begin
      prev <= raw;
      word <= cat[{1'b0, ofs} +: 8];
    end
  end

endmodule

// File: rtl/ad9253_frame_gen.sv
// AD9253-style serial lane word generator: preamble, test patterns,
// pass-through samples, error injection and per-lane bit slip.
module ad9253_frame_gen
  import ad9253_pkg::*;
#(
  parameter int         PRE_LEN = 16,
  parameter logic [8:0] PN_SEED = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  mode,
  input  logic [15:0] user_word,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        slip_req,
  input  logic        err_inj,
  output logic [7:0]  fco_word,
  output logic [7:0]  dco_a,
  output logic [7:0]  dco_b,
  output logic        busy,
  output logic [2:0]  slip_ofs,
  output logic [15:0] underrun_cnt
);

  state_t      state;
  logic [7:0]  pre_cnt;
  logic        chk_ph;
  logic [8:0]  lfsr;
  logic [13:0] ramp;
  logic [15:0] hold;
  logic        err_pend;

  logic        run_word;
  logic        pre_word;
  logic        is_norm;
  logic [22:0] pn_next;
  logic [15:0] sample;
  logic [7:0]  raw_fco;
  logic [7:0]  raw_a;
  logic [7:0]  raw_b;

  assign run_word = (state == ST_RUN) && en;
  assign pre_word = (state == ST_PRE) && en;
  assign is_norm  = (mode == MODE_NORMAL) || (mode > MODE_RAMP);
  assign pn_next  = pn9_word(lfsr);
  assign s_ready  = run_word && is_norm;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    sample = hold;
    unique case (1'b1)
      (mode == MODE_CHECKER): sample = chk_ph ? CHK_B : CHK_A;
      (mode == MODE_PN9):     sample = {pn_next[13:0], 2'b00};
      (mode == MODE_USER):    sample = user_word;
      (mode == MODE_RAMP):    sample = {ramp, 2'b00};
      default:                sample = s_valid ? s_data : hold;
    endcase
  end

  always_comb begin
    raw_fco = '0;
    raw_a   = '0;
    raw_b   = '0;
    if (pre_word) begin
      raw_fco = FCO_PAT;
    end else if (run_word) begin
      raw_fco = FCO_PAT;
      raw_a   = sample[15:8];
      raw_b   = sample[7:0] ^ {7'b0, err_pend};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      pre_cnt      <= '0;
      chk_ph       <= 1'b0;
      lfsr         <= PN_SEED;
      ramp         <= '0;
      hold         <= '0;
      err_pend     <= 1'b0;
      slip_ofs     <= '0;
      underrun_cnt <= '0;
    end else begin
      slip_ofs <= slip_ofs + {2'b0, slip_req};

      case (state)
        ST_IDLE: begin
          if (en) begin
            state   <= ST_PRE;
            pre_cnt <= '0;
            chk_ph  <= 1'b0;
            lfsr    <= PN_SEED;
            ramp    <= '0;
          end
        end
        ST_PRE: begin
          if (!en) begin
            state <= ST_IDLE;
          end else begin
            pre_cnt <= pre_cnt + 8'd1;
            if (pre_cnt == 8'(PRE_LEN - 1)) begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (!en) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Pattern state only advances on words that actually use it
      if (run_word) begin
        unique case (1'b1)
          (mode == MODE_CHECKER): chk_ph <= ~chk_ph;
          (mode == MODE_PN9):     lfsr   <= pn_next[22:14];
          (mode == MODE_USER):    ;
          (mode == MODE_RAMP):    ramp   <= ramp + 14'd1;
          default: begin
            if (s_valid) begin
              hold <= s_data;
            end else if (underrun_cnt != 16'hFFFF) begin
              underrun_cnt <= underrun_cnt + 16'd1;
            end
          end
        endcase
      end

      if (state != ST_IDLE && !en) begin
        err_pend <= 1'b0;
      end else if (err_inj) begin
        err_pend <= 1'b1;
      end else if (run_word) begin
        err_pend <= 1'b0;
      end
    end
  end

  ad9253_lane_slip u_fco (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_fco),
    .ofs  (slip_ofs),
    .word (fco_word)
  );

  ad9253_lane_slip u_lane_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_a),
    .ofs  (slip_ofs),
    .word (dco_a)
  );

  ad9253_lane_slip u_lane_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (raw_b),
    .ofs  (slip_ofs),
    .word (dco_b)
  );

endmodule
